// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed, active-low 7-segment scan (anode + segments),
// decodes each settled digit back to its 4-bit code and publishes a full 4-digit word
// once every digit position has been captured. Flags lost scanning after a long silence.
module seg7_scan_decoder #(
   parameter int unsigned SETTLE_CYCLES  = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 400000,
   parameter int unsigned CNT_W          = 19
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  anode_i,
   input  logic [6:0]  led_7seg_i,
   output logic [15:0] BCD_o,
   output logic        frame_valid_o,
   output logic [3:0]  err_mask_o,
   output logic        scan_lost_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      CAPTURED = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_MAX     = CNT_W'(TIMEOUT_CYCLES);

   // synchronizer stages plus the previous synchronized value for change detection
   logic [3:0]       anode_s1, anode_s2, anode_q;
   logic [6:0]       seg_s1, seg_s2, seg_q;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
   logic [CNT_W-1:0] tmo_cnt_q;

   logic             changed;
   logic             digit_valid;
   logic [1:0]       digit_idx;
   logic [3:0]       seg_code;
   logic             seg_err;
   logic             capture;
   logic [3:0]       cap_bit;
   logic             frame_done;
   logic             timeout_hit;

   logic [3:0][3:0]  shadow_code;
   logic [3:0]       shadow_err;
   logic [3:0]       cap_mask;

   // two-flop synchronizers and the one-cycle-old copy used to spot changes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         anode_s1 <= '1;
         anode_s2 <= '1;
         anode_q  <= '1;
         seg_s1   <= '1;
         seg_s2   <= '1;
         seg_q    <= '1;
      end else begin
         anode_s1 <= anode_i;
         anode_s2 <= anode_s1;
         anode_q  <= anode_s2;
         seg_s1   <= led_7seg_i;
         seg_s2   <= seg_s1;
         seg_q    <= seg_s2;
      end
   end

   assign changed = ({anode_s2, seg_s2} != {anode_q, seg_q});

   // anode decode: exactly one low bit selects a digit, anything else means no digit
   always_comb begin
      digit_valid = 1'b1;
      digit_idx   = '0;
      case (anode_s2)
         4'b1110: digit_idx = 2'd0;
         4'b1101: digit_idx = 2'd1;
         4'b1011: digit_idx = 2'd2;
         4'b0111: digit_idx = 2'd3;
         default: digit_valid = 1'b0;
      endcase
   end

   // segment pattern back to code; unknown patterns decode to E with the error bit set
   always_comb begin
      seg_err  = 1'b0;
      seg_code = 4'hE;
      case (seg_s2)
         7'b0000001: seg_code = 4'h0;
         7'b1001111: seg_code = 4'h1;
         7'b0010010: seg_code = 4'h2;
         7'b0000110: seg_code = 4'h3;
         7'b1001100: seg_code = 4'h4;
         7'b0100100: seg_code = 4'h5;
         7'b0100000: seg_code = 4'h6;
         7'b0001111: seg_code = 4'h7;
         7'b0000000: seg_code = 4'h8;
         7'b0000100: seg_code = 4'h9;
         7'b1111110: seg_code = 4'hF;
         7'b1111111: seg_code = 4'hA;
         default:    seg_err  = 1'b1;
      endcase
   end

   // dwell FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         stable_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         stable_cnt_q <= stable_cnt_d;
      end
   end

   // dwell FSM: count unchanged cycles on a selected digit, capture once per dwell
   always_comb begin
      state_d      = state_q;
      stable_cnt_d = stable_cnt_q;
      capture      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (digit_valid) begin
               state_d      = SETTLE;
               stable_cnt_d = '0;
            end
         end
         SETTLE: begin
            if (changed) begin
               state_d      = digit_valid ? SETTLE : IDLE;
               stable_cnt_d = '0;
            end else if (stable_cnt_q == SETTLE_LAST) begin
               capture = 1'b1;
               state_d = CAPTURED;
            end else begin
               stable_cnt_d = stable_cnt_q + CNT_W'(1);
            end
         end
         CAPTURED: begin
            if (changed) begin
               state_d      = digit_valid ? SETTLE : IDLE;
               stable_cnt_d = '0;
            end
         end
         default: begin
            state_d      = IDLE;
            stable_cnt_d = '0;
         end
      endcase
   end

   assign cap_bit     = capture ? (4'b0001 << digit_idx) : '0;
   assign frame_done  = (cap_mask == 4'b1111);
   assign timeout_hit = !capture && (tmo_cnt_q == TMO_LAST);

   // shadow capture, frame publication and scan-lost timeout; a completing frame beats a timeout
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_code   <= {4{4'hA}};
         shadow_err    <= '0;
         cap_mask      <= '0;
         tmo_cnt_q     <= '0;
         BCD_o         <= 16'hAAAA;
         err_mask_o    <= '0;
         frame_valid_o <= 1'b0;
         scan_lost_o   <= 1'b0;
      end else begin
         frame_valid_o <= frame_done;

         if (capture) begin
            shadow_code[digit_idx] <= seg_code;
            shadow_err[digit_idx]  <= seg_err;
         end

         if (capture)
            tmo_cnt_q <= '0;
         else if (tmo_cnt_q != TMO_MAX)
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);

         if (frame_done) begin
            BCD_o       <= shadow_code;
            err_mask_o  <= shadow_err;
            scan_lost_o <= 1'b0;
         end else if (timeout_hit) begin
            scan_lost_o <= 1'b1;
         end

         if (frame_done || timeout_hit)
            cap_mask <= cap_bit;
         else
            cap_mask <= cap_mask | cap_bit;
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: table-driven frames, hand-written corner sequences and random
// scanning, all checked every cycle against a run-length based reference model.
module tb_seg7_scan_decoder;

   localparam int S     = 8;
   localparam int T     = 200;
   localparam int DWELL = S + 4;

   localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110;
   localparam logic [6:0] P4 = 7'b1001100, P5 = 7'b0100100, P6 = 7'b0100000, P7 = 7'b0001111;
   localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0000100, PMIN = 7'b1111110, PBLK = 7'b1111111;

   localparam logic [6:0] REF_PAT [12] = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9, PMIN, PBLK};
   localparam logic [3:0] REF_CODE [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                           4'h8, 4'h9, 4'hF, 4'hA};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  anode = 4'b1111;
   logic [6:0]  seg = 7'b1111111;
   logic [15:0] BCD_o;
   logic        frame_valid_o;
   logic [3:0]  err_mask_o;
   logic        scan_lost_o;

   int n_vec = 0;
   int n_bad = 0;
   int frame_cnt = 0;

   seg7_scan_decoder #(
      .SETTLE_CYCLES  (S),
      .TIMEOUT_CYCLES (T),
      .CNT_W          (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .anode_i       (anode),
      .led_7seg_i    (seg),
      .BCD_o         (BCD_o),
      .frame_valid_o (frame_valid_o),
      .err_mask_o    (err_mask_o),
      .scan_lost_o   (scan_lost_o)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] ref_seg(input logic [6:0] p);
      for (int i = 0; i < 12; i++)
         if (p == REF_PAT[i]) return {1'b0, REF_CODE[i]};
      return {1'b1, 4'hE};
   endfunction

   function automatic int ref_digit(input logic [3:0] a);
      int zeros = 0;
      int idx = -1;
      for (int i = 0; i < 4; i++)
         if (!a[i]) begin
            zeros++;
            idx = i;
         end
      return (zeros == 1) ? idx : -1;
   endfunction

   function automatic logic [3:0] an_sel(input int d);
      logic [3:0] a;
      a = 4'b1111;
      a[d] = 1'b0;
      return a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      anode = a;
      seg   = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // reference model: a digit is captured two edges after the pin value has been seen on
   // S+1 consecutive sampling edges; frames publish one edge after all four digits exist
   int          m_run = 0;
   logic [10:0] m_last = '1;
   logic        q0_v = 1'b0, q1_v = 1'b0;
   int          q0_idx = 0, q1_idx = 0;
   logic [4:0]  q0_dec = '0, q1_dec = '0;
   logic        c_v;
   int          c_idx;
   logic [4:0]  c_dec;
   logic        f_now;
   int          d;
   logic [15:0] m_shadow = 16'hAAAA;
   logic [3:0]  m_sherr = '0, m_mask = '0;
   logic        m_pend = 1'b0;
   int          m_tc = 0;
   logic [15:0] m_bcd = 16'hAAAA;
   logic [3:0]  m_err = '0;
   logic        m_fv = 1'b0, m_lost = 1'b0;

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_run = 0; m_last = '1; q0_v = 1'b0; q1_v = 1'b0;
         m_shadow = 16'hAAAA; m_sherr = '0; m_mask = '0; m_pend = 1'b0; m_tc = 0;
         m_bcd = 16'hAAAA; m_err = '0; m_fv = 1'b0; m_lost = 1'b0;
      end else begin
         c_v = q0_v; c_idx = q0_idx; c_dec = q0_dec;
         q0_v = q1_v; q0_idx = q1_idx; q0_dec = q1_dec;
         q1_v = 1'b0;
         if ({anode, seg} == m_last) begin
            if (m_run < 100000) m_run++;
         end else begin
            m_run = 1;
         end
         m_last = {anode, seg};
         d = ref_digit(anode);
         if (m_run == S + 1 && d >= 0) begin
            q1_v = 1'b1; q1_idx = d; q1_dec = ref_seg(seg);
         end
         f_now = m_pend;
         m_fv  = 1'b0;
         if (f_now) begin
            m_bcd = m_shadow; m_err = m_sherr; m_fv = 1'b1; m_lost = 1'b0;
            m_mask = '0; m_pend = 1'b0;
         end
         if (c_v) begin
            m_tc = 0;
         end else if (m_tc < T) begin
            m_tc++;
            if (m_tc == T && !f_now) begin
               m_lost = 1'b1;
               m_mask = '0;
            end
         end
         if (c_v) begin
            m_shadow[c_idx*4 +: 4] = c_dec[3:0];
            m_sherr[c_idx] = c_dec[4];
            m_mask[c_idx] = 1'b1;
            if (m_mask == 4'hF) m_pend = 1'b1;
         end
      end
   end

   // per-cycle comparison against the model, plus frame pulse counting
   initial forever begin
      @(negedge clk);
      if (frame_valid_o) frame_cnt++;
      chk("bcd", {16'h0, BCD_o}, {16'h0, m_bcd});
      chk("frame_valid", {31'h0, frame_valid_o}, {31'h0, m_fv});
      chk("err_mask", {28'h0, err_mask_o}, {28'h0, m_err});
      chk("scan_lost", {31'h0, scan_lost_o}, {31'h0, m_lost});
   end

   typedef struct {
      logic [3:0][6:0] pat;
      logic [15:0]     bcd;
      logic [3:0]      err;
   } vec_t;

   vec_t tbl [7];
   int   fc0;
   int   sel, k;
   logic [3:0] ra;
   logic [6:0] rs;

   initial begin
      tbl[0] = '{{P1, P2, P3, P4}, 16'h1234, 4'b0000};
      tbl[1] = '{{PBLK, PMIN, PBLK, PBLK}, 16'hAFAA, 4'b0000};
      tbl[2] = '{{PBLK, PBLK, 7'b0110110, PBLK}, 16'hAAEA, 4'b0010};
      tbl[3] = '{{P5, P6, P7, P8}, 16'h5678, 4'b0000};
      tbl[4] = '{{P9, P0, P9, P0}, 16'h9090, 4'b0000};
      tbl[5] = '{{P8, P8, P8, P8}, 16'h8888, 4'b0000};
      tbl[6] = '{{7'b1010101, PBLK, P7, 7'b0111111}, 16'hEA7E, 4'b1001};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_bcd", {16'h0, BCD_o}, 32'h0000AAAA);
      chk("rst_flags", {25'h0, frame_valid_o, err_mask_o, scan_lost_o}, 32'h0);
      rst = 1'b1;

      for (int v = 0; v < 7; v++) begin
         fc0 = frame_cnt;
         for (int dg = 0; dg < 4; dg++) hold(an_sel(dg), tbl[v].pat[dg], DWELL);
         hold(4'b1111, PBLK, 4);
         chk("tbl_frames", frame_cnt - fc0, 1);
         chk("tbl_bcd", {16'h0, BCD_o}, {16'h0, tbl[v].bcd});
         chk("tbl_err", {28'h0, err_mask_o}, {28'h0, tbl[v].err});
         chk("tbl_lost", {31'h0, scan_lost_o}, 32'h0);
      end

      // segment glitch faster than the settle window: digit 0 never captured
      fc0 = frame_cnt;
      for (int g = 0; g < 8; g++) hold(an_sel(0), (g % 2 == 0) ? P1 : P2, S / 2);
      hold(an_sel(1), P4, DWELL); hold(an_sel(2), P5, DWELL); hold(an_sel(3), P6, DWELL);
      chk("glitch_noframe", frame_cnt - fc0, 0);
      hold(an_sel(0), P8, DWELL); hold(4'b1111, PBLK, 4);
      chk("glitch_frame", frame_cnt - fc0, 1);
      chk("glitch_bcd", {16'h0, BCD_o}, 32'h00006548);

      // two digits selected at once: no capture of either
      fc0 = frame_cnt;
      hold(4'b1100, P0, 50);
      hold(an_sel(1), P3, DWELL); hold(an_sel(2), P2, DWELL); hold(an_sel(3), P1, DWELL);
      chk("illegal_noframe", frame_cnt - fc0, 0);
      hold(an_sel(0), P4, DWELL); hold(4'b1111, PBLK, 4);
      chk("illegal_frame", frame_cnt - fc0, 1);
      chk("illegal_bcd", {16'h0, BCD_o}, 32'h00001234);

      // scanning stops after two digits: lost exactly T cycles after the last capture
      fc0 = frame_cnt;
      hold(an_sel(0), P7, DWELL); hold(an_sel(1), P7, DWELL);
      hold(4'b1111, PBLK, S + 2 + T - DWELL);
      chk("lost_early", {31'h0, scan_lost_o}, 32'h0);
      hold(4'b1111, PBLK, 1);
      chk("lost_set", {31'h0, scan_lost_o}, 32'h1);
      chk("lost_bcd_hold", {16'h0, BCD_o}, 32'h00001234);
      hold(an_sel(2), P3, DWELL); hold(an_sel(3), P9, DWELL);
      chk("lost_partial_dropped", frame_cnt - fc0, 0);
      chk("lost_still", {31'h0, scan_lost_o}, 32'h1);
      hold(an_sel(0), P1, DWELL); hold(an_sel(1), P2, DWELL); hold(4'b1111, PBLK, 4);
      chk("resume_frame", frame_cnt - fc0, 1);
      chk("resume_bcd", {16'h0, BCD_o}, 32'h00009321);
      chk("resume_lost", {31'h0, scan_lost_o}, 32'h0);

      // reset in the middle of a frame
      hold(an_sel(0), P9, DWELL); hold(an_sel(1), P9, DWELL / 2);
      #2 rst = 1'b0;
      #1;
      chk("midrst_bcd", {16'h0, BCD_o}, 32'h0000AAAA);
      chk("midrst_flags", {25'h0, frame_valid_o, err_mask_o, scan_lost_o}, 32'h0);
      anode = 4'b1111;
      seg   = PBLK;
      @(posedge clk);
      #1 rst = 1'b1;
      fc0 = frame_cnt;
      hold(an_sel(2), PMIN, DWELL); hold(an_sel(3), PBLK, DWELL);
      chk("midrst_noframe", frame_cnt - fc0, 0);
      hold(an_sel(0), P5, DWELL); hold(an_sel(1), P6, DWELL); hold(4'b1111, PBLK, 4);
      chk("midrst_frame", frame_cnt - fc0, 1);
      chk("midrst_newbcd", {16'h0, BCD_o}, 32'h0000AF65);

      // random scanning checked cycle by cycle against the model
      for (int r = 0; r < 300; r++) begin
         sel = int'($urandom_range(0, 7));
         if (sel < 4)      ra = an_sel(sel);
         else if (sel < 6) ra = 4'b1111;
         else              ra = 4'($urandom);
         k = int'($urandom_range(0, 13));
         rs = (k < 12) ? REF_PAT[k] : 7'($urandom);
         hold(ra, rs, int'($urandom_range(1, S + 5)));
      end
      hold(4'b1111, PBLK, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
